// File: rtl/lcd_win_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_win_ctrl
//   LCD window controller. Holds an IMG_W x IMG_H frame buffer, loaded
//   serially in raster order, and streams a movable WIN x WIN window of it
//   to the LCD driver, also in raster order. Shifts stop at the frame edges
//   instead of wrapping. A command is taken when cmd_valid=1 and busy=0.
//
//   Parameters:
//     DATA_W  pixel width in bits
//     IMG_W   frame width in pixels  (>= WIN)
//     IMG_H   frame height in pixels (>= WIN)
//     WIN     window edge length     (>= 1)
//
//   Ports:
//     clk           system clock, rising edge
//     reset         asynchronous, active-low reset
//     datain        pixel data while loading
//     cmd           command code (0 REFLASH, 1 LOAD, 2 RIGHT, 3 LEFT,
//                   4 UP, 5 DOWN, 6 CENTER, 7 MIRROR/REFLASH)
//     cmd_valid     command strobe
//     dataout       window pixel (registered)
//     output_valid  dataout qualifier (registered)
//     busy          high while a command executes
//
//   Optional feature (macro LCD_WIN_MIRROR_EN):
//     defined   - cmd 7 toggles a mirror flag that reverses the column order
//                 of every burst; LOAD and reset clear the flag.
//     undefined - cmd 7 behaves as REFLASH and no flag exists.
// ---------------------------------------------------------------------------
module lcd_win_ctrl #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int WIN    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = (NPIX  > 1) ? $clog2(NPIX)  : 1;
  localparam int X_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int W_W    = (WIN   > 1) ? $clog2(WIN)   : 1;

  localparam logic [X_W-1:0]    OX_MAX   = X_W'(IMG_W - WIN);
  localparam logic [Y_W-1:0]    OY_MAX   = Y_W'(IMG_H - WIN);
  localparam logic [X_W-1:0]    CX       = X_W'(IMG_W / 2 - WIN / 2);
  localparam logic [Y_W-1:0]    CY       = Y_W'(IMG_H / 2 - WIN / 2);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [W_W-1:0]    WIN_LAST = W_W'(WIN - 1);

  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5,
    CMD_CENTER  = 3'd6,
    CMD_MIRROR  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e              r_state;
  logic [X_W-1:0]      r_ox;
  logic [Y_W-1:0]      r_oy;
  logic [ADDR_W-1:0]   r_pix;      // load write pointer, equals raster index
  logic [W_W-1:0]      r_row;
  logic [W_W-1:0]      r_col;
  logic                r_done;     // last beat has been registered
  logic                r_busy;
  logic [DATA_W-1:0]   r_dout;
  logic                r_valid;
  logic [DATA_W-1:0]   r_fb [NPIX];
`ifdef LCD_WIN_MIRROR_EN
  logic                r_mirror;
`endif

  logic [X_W-1:0]      w_ox_nxt;
  logic [Y_W-1:0]      w_oy_nxt;
  logic [W_W-1:0]      w_col;
  logic [ADDR_W-1:0]   w_rd_addr;

  // Origin after the incoming command; shifts saturate at the frame edges.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ox_nxt = r_ox;
    w_oy_nxt = r_oy;
    case (cmd_e'(cmd))
      CMD_RIGHT:  if (r_ox < OX_MAX) w_ox_nxt = r_ox + 1'b1;
      CMD_LEFT:   if (r_ox != '0)    w_ox_nxt = r_ox - 1'b1;
      CMD_UP:     if (r_oy != '0)    w_oy_nxt = r_oy - 1'b1;
      CMD_DOWN:   if (r_oy < OY_MAX) w_oy_nxt = r_oy + 1'b1;
      CMD_CENTER: begin
        w_ox_nxt = CX;
        w_oy_nxt = CY;
      end
      default: ;
    endcase
  end

  // Column actually read for the current beat (reversed when mirrored).
  always_comb begin
`ifdef LCD_WIN_MIRROR_EN
    w_col = r_mirror ? (WIN_LAST - r_col) : r_col;
`else
    w_col = r_col;
`endif
    w_rd_addr = ADDR_W'((int'(r_oy) + int'(r_row)) * IMG_W
                        + int'(r_ox) + int'(w_col));
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ox     <= CX;
      r_oy     <= CY;
      r_pix    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
`ifdef LCD_WIN_MIRROR_EN
      r_mirror <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (cmd_valid) begin
            r_busy <= 1'b1;
            r_row  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
            if (cmd_e'(cmd) == CMD_LOAD) begin
              r_state  <= S_LOAD;
              r_pix    <= '0;
`ifdef LCD_WIN_MIRROR_EN
              r_mirror <= 1'b0;
`endif
            end else begin
              r_state <= S_OUT;
              r_ox    <= w_ox_nxt;
              r_oy    <= w_oy_nxt;
`ifdef LCD_WIN_MIRROR_EN
              if (cmd_e'(cmd) == CMD_MIRROR) r_mirror <= ~r_mirror;
`endif
            end
          end
        end

        S_LOAD: begin
          if (r_pix == LAST_PIX) begin
            r_ox    <= CX;
            r_oy    <= CY;
            r_state <= S_OUT;
          end else begin
            r_pix <= r_pix + 1'b1;
          end
        end

        S_OUT: begin
          if (r_done) begin
            // Edge after the last beat: drop valid and release busy together.
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_dout  <= r_fb[w_rd_addr];
            r_valid <= 1'b1;
            if (r_col == WIN_LAST) begin
              r_col <= '0;
              if (r_row == WIN_LAST) r_done <= 1'b1;
              else                   r_row  <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the frame buffer has no reset; its contents are meaningless until
  // loaded, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) r_fb[r_pix] <= datain;
  end

  assign dataout      = r_dout;
  assign output_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_win_ctrl
//   Self-checking bench for lcd_win_ctrl. A 6x6/3x3 instance runs a table of
//   commands with hand-computed origins, hand-written corner sequences
//   (busy handshake, reset during LOAD, cmd 7) and a randomized command run
//   against a behavioural model. An 8x5/4x4 instance checks the generic
//   dimensions and centring. Inputs change 1 ns after the rising edge,
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_win_ctrl;

  localparam int W  = 6, H = 6, WN = 3, N = W * H;
  localparam int CX = W / 2 - WN / 2, CY = H / 2 - WN / 2;
  localparam int W2 = 8, H2 = 5, WN2 = 4, N2 = W2 * H2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 6x6 / 3x3 instance
  logic       reset;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;

  // 8x5 / 4x4 instance
  logic       reset2;
  logic [7:0] datain2;
  logic [2:0] cmd2;
  logic       cmd_valid2;
  logic [7:0] dataout2;
  logic       output_valid2;
  logic       busy2;

  lcd_win_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .WIN(WN)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd),
    .cmd_valid(cmd_valid), .dataout(dataout),
    .output_valid(output_valid), .busy(busy)
  );

  lcd_win_ctrl #(.DATA_W(8), .IMG_W(W2), .IMG_H(H2), .WIN(WN2)) dut2 (
    .clk(clk), .reset(reset2), .datain(datain2), .cmd(cmd2),
    .cmd_valid(cmd_valid2), .dataout(dataout2),
    .output_valid(output_valid2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ox, m_oy;
  bit m_mir;
  int m_fb [N];
  int load_data [N];

  function automatic int model_pix(input int x, input int y);
    return m_fb[y * W + x];
  endfunction

  task automatic model_cmd(input int c);
    case (c)
      1: begin
        m_fb  = load_data;
        m_ox  = CX;
        m_oy  = CY;
        m_mir = 1'b0;
      end
      2: m_ox = (m_ox + 1 > W - WN) ? W - WN : m_ox + 1;
      3: m_ox = (m_ox - 1 < 0) ? 0 : m_ox - 1;
      4: m_oy = (m_oy - 1 < 0) ? 0 : m_oy - 1;
      5: m_oy = (m_oy + 1 > H - WN) ? H - WN : m_oy + 1;
      6: begin
        m_ox = CX;
        m_oy = CY;
      end
`ifdef LCD_WIN_MIRROR_EN
      7: m_mir = ~m_mir;
`endif
      default: ;
    endcase
  endtask

  logic [7:0] got_q [$];

  // Burst against the model's current origin, frame and mirror flag.
  task automatic check_model_burst(input string name);
    check($sformatf("%s_len", name), got_q.size(), WN * WN);
    for (int i = 0; i < WN * WN && i < got_q.size(); i++) begin
      int r, c;
      r = i / WN;
      c = m_mir ? (WN - 1 - i % WN) : (i % WN);
      check($sformatf("%s_beat%0d", name, i), got_q[i],
            model_pix(m_ox + c, m_oy + r));
    end
  endtask

  // Issue one command to dut and collect its burst into got_q. Checks the
  // first-beat latency and that busy falls together with output_valid.
  // pulse_beat > 0 raises cmd_valid (cmd=RIGHT) right after that beat has
  // been seen, for one clock edge.
  task automatic exec(input logic [2:0] c, input int pulse_beat);
    int  waited;
    int  first;
    bit  pulse;
    bit  ended;
    bit  busy_low_in_burst;
    waited = 0; first = -1; pulse = 0; ended = 0; busy_low_in_burst = 0;
    got_q.delete();
    while (busy !== 1'b0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (busy !== 1'b0) check("idle_wait_busy", busy, 0);
    cmd = c; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (c == 3'd1) begin
      for (int k = 0; k < N; k++) begin
        datain = 8'(load_data[k]);
        @(posedge clk); #1;
      end
    end
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (pulse) begin
        cmd_valid = 1'b0;
        pulse = 0;
      end
      if (output_valid === 1'b1) begin
        if (first < 0) first = i;
        if (busy !== 1'b1) busy_low_in_burst = 1;
        got_q.push_back(dataout);
        if (got_q.size() == pulse_beat) begin
          cmd = 3'd2; cmd_valid = 1'b1;
          pulse = 1;
        end
      end else if (got_q.size() > 0) begin
        ended = 1;
        break;
      end
    end
    check("burst_end_seen", ended, 1);
    check("first_beat_latency", first, 2);
    check("busy_high_in_burst", busy_low_in_burst, 0);
    check("busy_low_after_burst", busy, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] c;
    int         ox;
    int         oy;
    int         first;
    int         last;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Origins and corner pixels worked out by hand for frame data k.
    tbl[0]  = '{3'd1, 2, 2, 14, 28};   // LOAD -> centred
    tbl[1]  = '{3'd2, 3, 2, 15, 29};   // RIGHT
    tbl[2]  = '{3'd2, 3, 2, 15, 29};   // RIGHT clamps at 3
    tbl[3]  = '{3'd4, 3, 1,  9, 23};   // UP
    tbl[4]  = '{3'd3, 2, 1,  8, 22};   // LEFT
    tbl[5]  = '{3'd3, 1, 1,  7, 21};   // LEFT
    tbl[6]  = '{3'd3, 0, 1,  6, 20};   // LEFT -> (0,1)
    tbl[7]  = '{3'd3, 0, 1,  6, 20};   // LEFT clamps at 0
    tbl[8]  = '{3'd6, 2, 2, 14, 28};   // CENTER
    tbl[9]  = '{3'd5, 2, 3, 20, 34};   // DOWN
    tbl[10] = '{3'd5, 2, 3, 20, 34};   // DOWN clamps at 3
    tbl[11] = '{3'd4, 2, 2, 14, 28};   // UP
    tbl[12] = '{3'd4, 2, 1,  8, 22};   // UP
    tbl[13] = '{3'd4, 2, 0,  2, 16};   // UP -> top row
    tbl[14] = '{3'd4, 2, 0,  2, 16};   // UP clamps at 0
    tbl[15] = '{3'd0, 2, 0,  2, 16};   // REFLASH

    reset = 1'b0; datain = '0; cmd = '0; cmd_valid = 1'b0;
    reset2 = 1'b0; datain2 = '0; cmd2 = '0; cmd_valid2 = 1'b0;
    m_ox = CX; m_oy = CY; m_mir = 1'b0;
    for (int k = 0; k < N; k++) m_fb[k] = 0;

    // ---------------- reset state ----------------
    #12;
    check("rst_dataout", dataout, 0);
    check("rst_valid", output_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1; reset2 = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven command run ----------------
    for (int k = 0; k < N; k++) load_data[k] = k;
    for (int t = 0; t < 16; t++) begin
      exec(tbl[t].c, 0);
      model_cmd(int'(tbl[t].c));
      check($sformatf("tbl%0d_len", t), got_q.size(), WN * WN);
      check($sformatf("tbl%0d_first", t), got_q[0], tbl[t].first);
      check($sformatf("tbl%0d_last", t), got_q[WN * WN - 1], tbl[t].last);
      for (int i = 0; i < WN * WN && i < got_q.size(); i++)
        check($sformatf("tbl%0d_beat%0d", t, i), got_q[i],
              (tbl[t].oy + i / WN) * W + tbl[t].ox + i % WN);
    end

    // ---------------- cmd 7 after a fresh LOAD ----------------
    exec(3'd1, 0);
    model_cmd(1);
    exec(3'd7, 0);
    model_cmd(7);
    begin
`ifdef LCD_WIN_MIRROR_EN
      int exp7 [9] = '{16, 15, 14, 22, 21, 20, 28, 27, 26};
`else
      int exp7 [9] = '{14, 15, 16, 20, 21, 22, 26, 27, 28};
`endif
      check("cmd7_len", got_q.size(), 9);
      for (int i = 0; i < 9 && i < got_q.size(); i++)
        check($sformatf("cmd7_beat%0d", i), got_q[i], exp7[i]);
    end
    exec(3'd1, 0);                  // reload to clear any mirror state
    model_cmd(1);
    check_model_burst("reload");

    // ---------------- cmd_valid while busy is ignored ----------------
    exec(3'd0, 4);                  // RIGHT pulsed mid-burst
    check_model_burst("busy_pulse_mid");
    exec(3'd0, WN * WN);            // RIGHT pulsed on the edge busy falls
    check_model_burst("busy_pulse_edge");
    check("edge_pulse_not_taken_busy", busy, 0);
    @(negedge clk);
    check("edge_pulse_not_taken_valid", output_valid, 0);
    @(posedge clk); #1;
    exec(3'd0, 0);                  // origin must still be (2,2)
    check("after_pulses_first", got_q[0], 14);
    check_model_burst("after_pulses");

    // ---------------- randomized commands vs model ----------------
    for (int n = 0; n < 40; n++) begin
      logic [2:0] rc;
      rc = 3'($urandom_range(0, 7));
      if (rc == 3'd1)
        for (int k = 0; k < N; k++) load_data[k] = int'($urandom_range(0, 255));
      exec(rc, 0);
      model_cmd(int'(rc));
      check_model_burst($sformatf("rnd%0d_cmd%0d", n, rc));
    end

    // ---------------- reset in the middle of LOAD ----------------
    exec(3'd2, 0);                  // leave a burst so dataout is likely nonzero
    model_cmd(2);
    cmd = 3'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      datain = 8'(100 + k);
      @(posedge clk); #1;
    end
    check("midload_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("midload_rst_busy", busy, 0);
    check("midload_rst_valid", output_valid, 0);
    check("midload_rst_dataout", dataout, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) m_fb[k] = 100 + k;
    m_ox = CX; m_oy = CY; m_mir = 1'b0;
    exec(3'd0, 0);
    check_model_burst("after_midload_reset");
    exec(3'd4, 0);                  // UP x2 reaches the rows just written
    model_cmd(4);
    exec(3'd4, 0);
    model_cmd(4);
    check_model_burst("partial_rows");

    // ---------------- 8x5 frame, 4x4 window ----------------
    begin
      logic [7:0] q2 [$];
      bit         ended2;
      ended2 = 0;
      cmd2 = 3'd1; cmd_valid2 = 1'b1;
      @(posedge clk); #1;
      cmd_valid2 = 1'b0;
      for (int k = 0; k < N2; k++) begin
        datain2 = 8'(k);
        @(posedge clk); #1;
      end
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (output_valid2 === 1'b1) q2.push_back(dataout2);
        else if (q2.size() > 0) begin
          ended2 = 1;
          break;
        end
      end
      check("sweep_end_seen", ended2, 1);
      check("sweep_busy_low", busy2, 0);
      check("sweep_len", q2.size(), WN2 * WN2);
      // Origin (2,0): beat (r,c) is pixel (2+c, r) = r*8 + 2 + c.
      for (int i = 0; i < WN2 * WN2 && i < q2.size(); i++)
        check($sformatf("sweep_beat%0d", i), q2[i],
              (i / WN2) * W2 + 2 + i % WN2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
- Parametrised successor of the team's 6x6/3x3 LCD display controller.
- Holds an IMG_W x IMG_H pixel frame buffer loaded serially from `datain`.
- Streams a movable WIN x WIN window to the LCD driver in raster order.
- Adds over the previous generation:
  - generic dimensions;
  - a proper cmd_valid/busy handshake;
  - edge clamping on shifts;
  - a re-center command.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 6, frame width in pixels (>= WIN).
- IMG_H, 6, frame height in pixels (>= WIN).
- WIN, 3, window edge length in pixels (>= 1).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- datain  input  DATA_W  pixel data during LOAD.
- cmd  input  3  command code.
- cmd_valid  input  1  command strobe.
- dataout  output  DATA_W  window pixel.
- output_valid  output  1  dataout qualifier.
- busy  output  1  high while a command executes; commands are not accepted.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-low.
  - On reset: dataout=0, output_valid=0, busy=0, state=IDLE, origin=(CX,CY).
  - CX = IMG_W/2 - WIN/2, CY = IMG_H/2 - WIN/2, integer division. Default gives (2,2).
  - Frame buffer contents are not reset and are undefined until the first LOAD.
- Origin: (ox,oy) is the top-left pixel of the window.
  - Legal range: 0 <= ox <= IMG_W-WIN and 0 <= oy <= IMG_H-WIN.
  - Counters are clog2-sized so that no wrap is possible.
- Accept: a command is accepted at a rising edge where cmd_valid=1 and busy=0 (edge T0).
  - busy=1 from T0 onward.
  - cmd_valid while busy=1 is ignored; there is no queueing.
- Command codes:
  - 0 REFLASH: origin unchanged.
  - 1 LOAD: see LOAD state.
  - 2 RIGHT: ox+1, clamped at IMG_W-WIN.
  - 3 LEFT: ox-1, clamped at 0.
  - 4 UP: oy-1, clamped at 0.
  - 5 DOWN: oy+1, clamped at IMG_H-WIN.
  - 6 CENTER: origin=(CX,CY).
  - 7: see Optional Feature.
  - A clamped shift still produces a full output burst.
- States:
  - IDLE: busy=0.
  - LOAD:
    - datain is sampled on the IMG_W*IMG_H edges following T0, in raster order: pixel k is stored at (k%IMG_W, k/IMG_W).
    - After the last sample, origin=(CX,CY); go to OUT.
  - OUT:
    - Entered at T0 for non-LOAD commands, with the origin updated at T0.
    - For WIN*WIN consecutive cycles: output_valid=1 and dataout=pixel(ox+c, oy+r), in raster order (r outer, c inner).
    - dataout and output_valid are registered. The first valid beat is registered on the edge after entry into OUT.
    - On the edge after the last beat: output_valid=0, busy=0, go to IDLE.
    - Outside OUT, output_valid=0 and dataout holds its last value.
- Latency:
  - Non-LOAD command: first beat visible after edge T0+1; busy falls after edge T0+WIN*WIN+1.
  - LOAD: first beat after edge T0+IMG_W*IMG_H+1.
- Reset mid-operation: any state returns to IDLE immediately.
  - A partial LOAD leaves a partially written buffer; this is legal, and no error is flagged.
- Simultaneous events: a cmd_valid on the same edge on which busy falls is not accepted. busy is still 1 at that edge.

Optional Feature:
- Macro: LCD_WIN_MIRROR_EN.
- Defined:
  - cmd 7 = MIRROR: toggles an internal mirror flag (reset value 0). Origin is unchanged, and a full burst is output.
  - While the flag is 1, every OUT burst emits columns in reverse order: c = WIN-1 down to 0.
  - LOAD clears the flag.
- Undefined: cmd 7 behaves exactly as REFLASH, and no flag logic is synthesised.

Test Plan:
- Reset, then LOAD of 6x6 data 0..35 -> nine beats 14,15,16,20,21,22,26,27,28; busy low one cycle after the last beat.
- RIGHT after the load -> 15,16,17,21,22,23,27,28,29; second RIGHT -> origin clamps at ox=3, burst repeated identically.
- UP from (2,2), then LEFT x3 -> the LEFT bursts end with origin (0,1): 6,7,8,12,13,14,18,19,20; CENTER -> 14..28 burst as after load.
- cmd_valid pulsed with cmd=2 while busy -> ignored, origin unchanged; reset asserted mid-LOAD -> outputs zero and busy=0 asynchronously, next REFLASH centers at (2,2).
- Parameter sweep IMG_W=8, IMG_H=5, WIN=4, data k -> after LOAD the origin is (2,0) and the window starts with 2,3,4,5,10.
- With LCD_WIN_MIRROR_EN: LOAD 0..35 then cmd 7 -> 16,15,14,22,21,20,28,27,26. Without the macro: cmd 7 gives the REFLASH burst.
